// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encoding and duty-bus slicing.
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  // Widest supported duty word and channel count; the slice helper works on a bus this wide.
  localparam int unsigned MaxBits     = 32;
  localparam int unsigned MaxChannels = 32;
  localparam int unsigned DutyBusW    = MaxBits * MaxChannels;

  function automatic logic [MaxBits-1:0] duty_slice(input logic [DutyBusW-1:0] bus,
                                                    input int unsigned        bits,
                                                    input int unsigned        chan);
    logic [DutyBusW-1:0] shifted;
    logic [MaxBits-1:0]  mask;
    shifted = bus >> (chan * bits);
    mask    = {MaxBits{1'b1}} >> (MaxBits - bits);
    return shifted[MaxBits-1:0] & mask;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: edge/center counter, active period and mode, boundary strobe and sync.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            apply_i,
  input  logic [BITS-1:0] period_shadow_i,
  input  logic            center_shadow_i,
  output logic [BITS-1:0] cnt_o,
  output logic            boundary_o,
  output logic            sync_o
);

  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] period_q, period_d;
  logic            center_q, center_d;
  logic            dir_q, dir_d;  // 1 = counting down
  logic            sync_q, sync_d;
  logic            boundary;

  always_comb begin
    boundary = 1'b0;
    if (period_q == '0) begin
      boundary = 1'b1;
    end else if (center_q == PWM_EDGE) begin
      boundary = (cnt_q >= period_q);
    end else begin
      // P=1 never turns around, so its last value is reached while still counting up.
      boundary = (cnt_q == BITS'(1)) && (dir_q || (period_q == BITS'(1)));
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    period_d = period_q;
    center_d = center_q;
    sync_d   = enable_i && (cnt_q == '0);
    if (!enable_i || boundary) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (center_q == PWM_CENTER) begin
      if (dir_q) begin
        cnt_d = cnt_q - BITS'(1);
      end else if (cnt_q == period_q) begin
        dir_d = 1'b1;
        cnt_d = cnt_q - BITS'(1);
      end else begin
        cnt_d = cnt_q + BITS'(1);
      end
    end else begin
      cnt_d = cnt_q + BITS'(1);
    end
    if (apply_i) begin
      period_d = period_shadow_i;
      center_d = center_shadow_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      period_q <= '0;
      center_q <= PWM_EDGE;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      center_q <= center_d;
      sync_q   <= sync_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign boundary_o = boundary;
  assign sync_o     = sync_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: double-buffered period/mode/duty over one shared timebase.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned BITS     = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     load,
  input  logic [BITS-1:0]          period,
  input  logic                     center,
  input  logic [CHANNELS*BITS-1:0] dty,
  output logic [CHANNELS-1:0]      pwm,
  output logic                     sync,
  output logic                     pending
);

  logic [BITS-1:0] period_sh_q;
  logic            center_sh_q;
  logic            pending_q, pending_d;
  logic            apply;
  logic            boundary;
  logic [BITS-1:0] cnt;

  // Disabled timebase accepts shadow contents every cycle; running one only at a boundary.
  assign apply = pending_q && (boundary || !enable);

  always_comb begin
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh_q <= '0;
      center_sh_q <= PWM_EDGE;
      pending_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        period_sh_q <= period;
        center_sh_q <= center;
      end
    end
  end

  pwm_timebase #(
    .BITS (BITS)
  ) u_timebase (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable),
    .apply_i         (apply),
    .period_shadow_i (period_sh_q),
    .center_shadow_i (center_sh_q),
    .cnt_o           (cnt),
    .boundary_o      (boundary),
    .sync_o          (sync)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [BITS-1:0] duty_in;
    logic [BITS-1:0] duty_sh_q;
    logic [BITS-1:0] duty_act_q;
    logic            pwm_q;

    assign duty_in = BITS'(duty_slice(DutyBusW'(dty), BITS, c));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
        pwm_q      <= 1'b0;
      end else begin
        // The active word takes the old shadow even when a load lands on the same edge.
        if (apply) begin
          duty_act_q <= duty_sh_q;
        end
        if (load) begin
          duty_sh_q <= duty_in;
        end
        pwm_q <= enable && (cnt < duty_act_q);
      end
    end

    assign pwm[c] = pwm_q;
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi with hand-computed expected waveforms.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] period = '0;
  logic        center = 1'b0;
  logic [63:0] dty = '0;
  logic [3:0]  pwm;
  logic        sync;
  logic        pending;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_multi #(
    .BITS     (16),
    .CHANNELS (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (load),
    .period  (period),
    .center  (center),
    .dty     (dty),
    .pwm     (pwm),
    .sync    (sync),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a configuration while disabled, lets it reach the active registers, then enables.
  // The next tick samples output position 0.
  task automatic configure(input logic [15:0] p, input logic c, input logic [63:0] d);
    enable = 1'b0;
    period = p;
    center = c;
    dty    = d;
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pwm, sync, pending} !== 6'b0) begin
      $display("FAIL reset_initial: got %b expected %b", {pwm, sync, pending}, 6'b0);
    end else n_pass++;
    tick();
    rst_n = 1'b1;
    configure(16'd9, 1'b0, {16'd5, 16'd10, 16'd0, 16'd3});
    tick();  // pos0
    tick();  // pos1
    tick();  // pos2
    load = 1'b1;
    tick();  // pos3, counter now holds 4
    load = 1'b0;
    n_checks++;
    if (pwm !== 4'b1100) begin
      $display("FAIL reset_prerun_pwm: got %b expected %b", pwm, 4'b1100);
    end else n_pass++;
    n_checks++;
    if (pending !== 1'b1) begin
      $display("FAIL reset_prerun_pending: got %b expected %b", pending, 1'b1);
    end else n_pass++;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    n_checks++;
    if ({pwm, sync, pending} !== 6'b0) begin
      $display("FAIL reset_async: got %b expected %b", {pwm, sync, pending}, 6'b0);
    end else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({pwm, sync, pending} !== 6'b0) begin
        $display("FAIL reset_release i=%0d: got %b expected %b", i, {pwm, sync, pending}, 6'b0);
      end else n_pass++;
    end
  endtask

  task automatic test_edge();
    logic [4:0] exp;
    int pos;
    configure(16'd9, 1'b0, {16'd5, 16'd10, 16'd0, 16'd3});
    for (int i = 0; i < 30; i++) begin
      tick();
      pos = i % 10;
      exp = {pos == 0, pos < 5, 1'b1, 1'b0, pos < 3};
      n_checks++;
      if ({sync, pwm} !== exp) begin
        $display("FAIL edge_mode i=%0d: got sync,pwm=%b expected %b", i, {sync, pwm}, exp);
      end else n_pass++;
    end
  endtask

  task automatic test_center();
    int cnt_seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    logic [4:0] exp;
    int pos;
    int c;
    configure(16'd4, 1'b1, {16'd3, 16'd5, 16'd0, 16'd2});
    for (int i = 0; i < 16; i++) begin
      tick();
      pos = i % 8;
      c   = cnt_seq[pos];
      exp = {pos == 0, c < 3, 1'b1, 1'b0, c < 2};
      n_checks++;
      if ({sync, pwm} !== exp) begin
        $display("FAIL center_mode i=%0d: got sync,pwm=%b expected %b", i, {sync, pwm}, exp);
      end else n_pass++;
    end
  endtask

  task automatic test_mid_update();
    logic exp;
    configure(16'd9, 1'b0, {16'd0, 16'd0, 16'd0, 16'd3});
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = (i < 10) ? ((i % 10) < 3) : ((i % 10) < 7);
      n_checks++;
      if (pwm[0] !== exp) begin
        $display("FAIL mid_update_pwm0 i=%0d: got %b expected %b", i, pwm[0], exp);
      end else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (pending !== 1'b1) begin
          $display("FAIL mid_update_pending_set: got %b expected %b", pending, 1'b1);
        end else n_pass++;
      end
      if (i == 10) begin
        n_checks++;
        if ({sync, pending} !== 2'b10) begin
          $display("FAIL mid_update_pending_clr: got sync,pending=%b expected %b",
                   {sync, pending}, 2'b10);
        end else n_pass++;
      end
      if (i == 3) begin
        dty  = {16'd0, 16'd0, 16'd0, 16'd7};
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_load_boundary();
    logic exp;
    int   pos;
    configure(16'd9, 1'b0, {16'd0, 16'd0, 16'd0, 16'd7});
    for (int i = 0; i < 30; i++) begin
      tick();
      pos = i % 10;
      if (i < 10) exp = pos < 7;
      else if (i < 20) exp = pos < 2;
      else exp = pos < 6;
      n_checks++;
      if (pwm[0] !== exp) begin
        $display("FAIL load_boundary_pwm0 i=%0d: got %b expected %b", i, pwm[0], exp);
      end else n_pass++;
      if (i == 10 || i == 15) begin
        n_checks++;
        if (pending !== 1'b1) begin
          $display("FAIL load_boundary_pending_held i=%0d: got %b expected %b", i, pending, 1'b1);
        end else n_pass++;
      end
      if (i == 20) begin
        n_checks++;
        if (pending !== 1'b0) begin
          $display("FAIL load_boundary_pending_clr: got %b expected %b", pending, 1'b0);
        end else n_pass++;
      end
      load = 1'b0;
      if (i == 3) begin
        dty  = {16'd0, 16'd0, 16'd0, 16'd2};
        load = 1'b1;
      end
      if (i == 8) begin
        dty  = {16'd0, 16'd0, 16'd0, 16'd6};
        load = 1'b1;
      end
    end
  endtask

  task automatic test_disable();
    configure(16'd9, 1'b0, {16'd10, 16'd0, 16'd0, 16'd6});
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (pwm !== 4'b1001) begin
      $display("FAIL disable_before: got %b expected %b", pwm, 4'b1001);
    end else n_pass++;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({sync, pwm} !== 5'b0) begin
      $display("FAIL disable_outputs: got sync,pwm=%b expected %b", {sync, pwm}, 5'b0);
    end else n_pass++;
    dty  = {16'd10, 16'd0, 16'd0, 16'd2};
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if ({pending, pwm} !== 5'b10000) begin
      $display("FAIL disable_pending_set: got pending,pwm=%b expected %b", {pending, pwm}, 5'b10000);
    end else n_pass++;
    tick();
    n_checks++;
    if (pending !== 1'b0) begin
      $display("FAIL disable_pending_clr: got %b expected %b", pending, 1'b0);
    end else n_pass++;
    enable = 1'b1;
    tick();
    n_checks++;
    if ({sync, pwm} !== 5'b11001) begin
      $display("FAIL reenable_pos0: got sync,pwm=%b expected %b", {sync, pwm}, 5'b11001);
    end else n_pass++;
    tick();
    n_checks++;
    if ({sync, pwm} !== 5'b01001) begin
      $display("FAIL reenable_pos1: got sync,pwm=%b expected %b", {sync, pwm}, 5'b01001);
    end else n_pass++;
    tick();
    n_checks++;
    if ({sync, pwm} !== 5'b01000) begin
      $display("FAIL reenable_pos2: got sync,pwm=%b expected %b", {sync, pwm}, 5'b01000);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_mid_update();
    test_load_boundary();
    test_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator and parametrised successor to the single-channel free-running `pwm`. `CHANNELS` outputs share one programmable timebase with edge-aligned or center-aligned counting. Duty, period and mode are double-buffered so updates take effect only at a period boundary. It sits between the register/SPI decode layer and the output pins of the pwmout plugin.

## Interface
- `BITS`, 16: width of counter, period and each duty word.
- `CHANNELS`, 4: number of PWM outputs; range 1–32.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run timebase; low holds counter and outputs.
- `load`  in  1  single-cycle strobe that captures `period`, `center`, `dty` into shadow registers.
- `period`  in  BITS  top count P.
- `center`  in  1  0 = edge-aligned, 1 = center-aligned.
- `dty`  in  CHANNELS*BITS  duty words; channel c at bits [c*BITS +: BITS].
- `pwm`  out  CHANNELS  registered PWM outputs.
- `sync`  out  1  one-cycle pulse on the first output cycle of each period.
- `pending`  out  1  shadow holds values not yet applied.

## Operation
- Reset, asynchronous, low: cnt=0, dir=up, all shadow and active registers 0, `pwm`=0, `sync`=0, `pending`=0. Reset takes effect immediately, including mid-period.
- Edge mode: cnt runs 0,1,…,P then wraps to 0. Period length is P+1 cycles.
- Center mode: cnt runs 0,1,…,P,P−1,…,1 then back to 0. Period length is 2P cycles; P=1 gives 0,1,0,1.
- P=0 (either mode): cnt stays 0. Every cycle is a boundary.
- Compare: `pwm[c]` is next (cnt < D_c), using the active duty D_c (unsigned, BITS wide).
  - D=0: output constant low.
  - D>P: output constant high.
  - Edge mode: high for D cycles per period.
  - Center mode: high for 2D−1 cycles per period, centred on cnt=0.
- Boundary: the cycle in which cnt holds the last value of its period. On that clock edge:
  - cnt←0, dir←up.
  - If `pending`: active period, mode and duties ← shadow, and `pending`←0.
- `load`: shadow ← inputs and `pending`←1, regardless of `enable`. If `load` coincides with a boundary, the active registers take the old shadow contents, the new values land in shadow, and `pending` stays 1 until the next boundary.
- `enable` low:
  - cnt←0 and dir←up.
  - `pwm`←0 and `sync`←0 on the next edge.
  - Any pending shadow is transferred to active every cycle, so `pending` clears one cycle after `load`.
- `enable` rising: counting starts at cnt=0 with the current active values.

## Timing
- `pwm` and `sync` are registered. Both lag the counter value they reflect by one cycle.
- `sync` = (cnt==0 && enable), registered. It is high exactly in the first cycle of each period's output.
- New values become visible on `pwm` in the cycle where `sync` is high after the applying boundary. That is 1 cycle after the boundary edge.
- `pending` rises 1 cycle after `load` and falls 1 cycle after the applying edge.
- Single clock domain throughout. No combinational path from any input to any output.

## Structure
- Package `pwm_pkg`:
  - Mode encoding constants `PWM_EDGE` and `PWM_CENTER`.
  - Helper function that slices channel c out of a flat duty bus.
- Sub-module `pwm_timebase`: owns cnt, dir, active period/mode, and the boundary/`sync` generation. It outputs cnt and a boundary strobe.
- Top level contains:
  - Shadow/active duty register arrays.
  - `pending` flag.
  - A generate loop of per-channel comparators with output flops.

## Test plan
- Reset: run edge mode P=9, then assert `rst_n` low at cnt=4. `pwm`=0, `sync`=0 and `pending`=0 without waiting for a clock edge. After release, outputs stay 0 until `enable`.
- Edge mode: P=9, duties {3,0,10,5}, `load`, `enable`. Every 10 cycles `sync` pulses. pwm0 is high 3 cycles, pwm1 is never high, pwm2 is always high, pwm3 is high 5 cycles, each starting on the `sync` cycle.
- Center mode: P=4, D0=2. Period is 8 cycles, cnt sequence 0,1,2,3,4,3,2,1. pwm0 is high at output positions 0, 1 and 7, i.e. 3 contiguous cycles across the wrap.
- Mid-period update: edge mode P=9 with D0=3, then `load` D0=7 at cnt=4. The current period still shows 3 high cycles and `pending`=1. The next period shows 7 high cycles, and `pending` has dropped by that period's `sync` cycle.
- Load on boundary: `load` D0=6 in the cycle cnt=9. The following period uses the old shadow value and `pending` stays 1. D0=6 appears one period later.
- Disable: drop `enable` at cnt=5. `pwm`=0 next cycle. A `load` while disabled clears `pending` after 1 cycle. Re-enabling gives `sync` on the first output cycle with the new duty.
